// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit period.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // Default clk cycles per UART bit, shared by uart_tx and uart_rx.
    localparam int UART_CLKDIV = 128;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_e;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk cycles from input change to output change.
// Backpressure: none, free-running.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; both come out of reset at RST_VAL so the
    // output does not glitch when reset releases on an idle line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling with a CLKDIV-cycle bit timer.
// Latency: result pulse one cycle after the stop-bit mid-sample (~2 + 9.5*CLKDIV cycles after start edge).
// Backpressure: none; each good byte overwrites rx_data whether consumed or not.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKDIV = UART_CLKDIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_frame_err
);

    localparam int            CW        = $clog2(CLKDIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKDIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic           line;
    logic           line_prev_q;

    uart_rx_state_e state_q,  state_d;
    logic [CW-1:0]  bitcnt_q, bitcnt_d;
    logic [2:0]     bitidx_q, bitidx_d;
    logic [7:0]     shift_q,  shift_d;
    logic [7:0]     data_q,   data_d;
    logic           valid_q,  valid_d;
    logic           ferr_q,   ferr_d;
    logic           busy_q,   busy_d;

    // rx_pin is asynchronous; everything below only ever looks at 'line'.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (rx_pin),
        .q_o    (line)
    );

    // Next-state logic: start-bit qualification, data shifting, stop check.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        bitidx_d = bitidx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Falling edge: wait half a bit to land mid start bit.
                if (!line && line_prev_q) begin
                    bitcnt_d = HALF_LOAD;
                    state_d  = ST_START;
                end
            end

            ST_START: begin
                if (bitcnt_q == '0) begin
                    if (!line) begin
                        bitcnt_d = FULL_LOAD;
                        bitidx_d = '0;
                        state_d  = ST_DATA;
                    end else begin
                        // Line went back high: treat as a glitch, no pulse.
                        state_d = ST_IDLE;
                    end
                end else begin
                    bitcnt_d = bitcnt_q - CNT_ONE;
                end
            end

            ST_DATA: begin
                if (bitcnt_q == '0) begin
                    shift_d  = {line, shift_q[7:1]};
                    bitcnt_d = FULL_LOAD;
                    if (bitidx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bitidx_d = bitidx_q + 3'd1;
                    end
                end else begin
                    bitcnt_d = bitcnt_q - CNT_ONE;
                end
            end

            ST_STOP: begin
                if (bitcnt_q == '0) begin
                    if (line) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        // Low stop bit: report and park until the line idles.
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    bitcnt_d = bitcnt_q - CNT_ONE;
                end
            end

            ST_BREAK: begin
                if (line) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; line_prev_q tracks every cycle so an edge
    // arriving just as STOP returns to IDLE is still seen next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            bitidx_q    <= '0;
            shift_q     <= '0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            busy_q      <= 1'b0;
            line_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            bitidx_q    <= bitidx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            busy_q      <= busy_d;
            line_prev_q <= line;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx at CLKDIV=16.
// A behavioural line driver produces 8N1 frames; expected bytes come from what was sent.
// Observed pulses are collected by a negedge monitor and compared to the sent-byte queue.
module tb_uart_rx;

    localparam int CLKDIV = 16;
    localparam int BT     = CLKDIV * 10;   // nominal bit time in time units (clk period 10)

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       rx_pin = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc         = 0;
    int err_cnt     = 0;
    int both_cnt    = 0;
    int wide_cnt    = 0;
    int busy_cycles = 0;
    int valid_cyc   = 0;
    bit prev_valid  = 1'b0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         chk_idx   = 0;
    int         start_cyc = 0;
    logic [7:0] exp_data  = 8'h00;

    uart_rx #(
        .CLKDIV (CLKDIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_pin       (rx_pin),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            valid_cyc <= cyc;
        end
        if (rx_frame_err)             err_cnt     <= err_cnt + 1;
        if (rx_valid && rx_frame_err) both_cnt    <= both_cnt + 1;
        if (rx_valid && prev_valid)   wide_cnt    <= wide_cnt + 1;
        if (rx_busy)                  busy_cycles <= busy_cycles + 1;
        prev_valid <= rx_valid;
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Compare everything received since the last call against what was sent.
    task automatic check_queues(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = chk_idx; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
        chk_idx = exp_q.size();
    endtask

    // Drive one 8N1 frame with bit time bt; a good stop bit enters the model.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bt, input bit align);
        if (align) begin
            @(negedge clk);
            #2;
        end
        start_cyc = cyc;
        rx_pin = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            #(bt);
        end
        rx_pin = stop_ok;
        #(bt);
        if (stop_ok) begin
            exp_q.push_back(b);
            exp_data = b;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int         base_err;
        int         base_busy;
        logic [7:0] b;
        int         bt;
        bit         al;

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b0;
        #1;
        check("rst_data",  rx_data,      8'h00);
        check("rst_valid", rx_valid,     1'b0);
        check("rst_ferr",  rx_frame_err, 1'b0);
        check("rst_busy",  rx_busy,      1'b0);
        repeat (4) @(negedge clk);
        check("rst_busy_clk", rx_busy, 1'b0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_busy", rx_busy, 1'b0);

        // Single good frame 0x55, with latency window.
        base_err = err_cnt;
        send_frame(8'h55, 1'b1, BT, 1'b1);
        repeat (20) @(negedge clk);
        check_queues("f55");
        check("f55_data", rx_data, 8'h55);
        check("f55_noerr", err_cnt - base_err, 0);
        check_range("f55_latency", valid_cyc - start_cyc, 2 + (19 * CLKDIV) / 2 - 1, 2 + (19 * CLKDIV) / 2 + 3);

        // Five-cycle low glitch on an idle line.
        base_err  = err_cnt;
        base_busy = busy_cycles;
        @(negedge clk);
        #2 rx_pin = 1'b0;
        #50 rx_pin = 1'b1;
        repeat (40) @(negedge clk);
        check_range("glitch_busy_seen", busy_cycles - base_busy, 1, CLKDIV);
        check("glitch_busy_end", rx_busy, 1'b0);
        check("glitch_noerr", err_cnt - base_err, 0);
        check_queues("glitch");

        // Bad stop bit followed by a 40-cycle break.
        base_err = err_cnt;
        send_frame(8'hA3, 1'b0, BT, 1'b1);
        #400;
        check("brk_ferr_once", err_cnt - base_err, 1);
        check("brk_data_kept", rx_data, exp_data);
        check("brk_busy_held", rx_busy, 1'b1);
        check_queues("brk");
        rx_pin = 1'b1;
        repeat (5) @(negedge clk);
        check("brk_busy_release", rx_busy, 1'b0);
        repeat (20) @(negedge clk);

        // Back-to-back frames, one stop bit each.
        send_frame(8'h00, 1'b1, BT, 1'b1);
        send_frame(8'hFF, 1'b1, BT, 1'b0);
        send_frame(8'hA5, 1'b1, BT, 1'b0);
        repeat (20) @(negedge clk);
        check_queues("b2b");
        check("b2b_data", rx_data, 8'hA5);

        // Reset in the middle of bit 4 of 0x3C, held to the end of that frame.
        b = 8'h3C;
        @(negedge clk);
        #2 rx_pin = 1'b0;
        #(BT);
        for (int i = 0; i < 4; i++) begin
            rx_pin = b[i];
            #(BT);
        end
        rx_pin = b[4];
        #(BT / 2);
        rst = 1'b0;
        exp_data = 8'h00;
        #1;
        check("rstmid_busy", rx_busy, 1'b0);
        check("rstmid_data", rx_data, 8'h00);
        #(BT / 2 - 1);
        for (int i = 5; i < 8; i++) begin
            rx_pin = b[i];
            #(BT);
        end
        rx_pin = 1'b1;
        #(2 * BT);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_queues("rstmid_abort");
        send_frame(8'hC3, 1'b1, BT, 1'b1);
        repeat (20) @(negedge clk);
        check_queues("rstmid_next");
        check("rstmid_next_data", rx_data, 8'hC3);

        // Bit-rate tolerance: about -3% and +3% bit period.
        for (int k = 0; k < 4; k++) begin
            bt = (k < 2) ? (BT - BT * 3 / 100) : (BT + BT * 3 / 100);
            send_frame(8'h96, 1'b1, bt, 1'b1);
            repeat (20) @(negedge clk);
            check($sformatf("rate%0d_data", k), rx_data, 8'h96);
        end
        check_queues("rate");

        // Random bytes, random rate within tolerance, random gaps.
        for (int k = 0; k < 10; k++) begin
            b  = 8'($urandom_range(0, 255));
            bt = $urandom_range(BT - 4, BT + 4);
            al = 1'($urandom_range(0, 1));
            send_frame(b, 1'b1, bt, al);
        end
        repeat (20) @(negedge clk);
        check_queues("rand");
        check("rand_data", rx_data, exp_data);

        // Global pulse properties over the whole run.
        check("never_both", both_cnt, 0);
        check("valid_one_cycle", wide_cnt, 0);
        check("end_idle", rx_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKDIV, default 128, meaning clk cycles per UART bit; legal range is 4 or more.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port rx_pin, input, 1 bit: asynchronous serial line; idle high; frame is 8N1, LSB first.
REQ-005 SHALL have port rx_data, output, 8 bits: last correctly framed byte.
REQ-006 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data is updated.
REQ-007 SHALL have port rx_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 SHALL have port rx_frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.

Function
REQ-009 SHALL pass rx_pin through a 2-flop synchronizer (reset value 1) before any use; "line" below means the synchronizer output.
REQ-010 SHALL implement states IDLE, START, DATA, STOP and BREAK.
REQ-011 SHALL use a down-counter bitcnt of width $clog2(CLKDIV) and a 3-bit bit index.
REQ-012 IDLE: when line is 0 and was 1 the previous cycle (falling edge), SHALL load bitcnt = CLKDIV/2-1 (integer division) and go to START.
REQ-013 START: SHALL decrement bitcnt; at bitcnt==0, if line==0 it SHALL load bitcnt = CLKDIV-1, clear the bit index and go to DATA; otherwise it SHALL return to IDLE with no output pulse (glitch reject).
REQ-014 DATA: SHALL decrement bitcnt; at bitcnt==0 it SHALL shift line into an internal shift register at position MSB (right shift, LSB first) and reload CLKDIV-1.
REQ-015 DATA: after the 8th sample (bit index 7), SHALL go to STOP.
REQ-016 STOP: at bitcnt==0, if line==1 it SHALL copy the shift register to rx_data, pulse rx_valid for exactly one cycle and go to IDLE.
REQ-017 STOP: at bitcnt==0, if line==0 it SHALL pulse rx_frame_err for exactly one cycle, leave rx_data unchanged and go to BREAK.
REQ-018 BREAK: SHALL stay until line==1, then go to IDLE; no falling edge is accepted while in BREAK.
REQ-019 The rx_valid / rx_frame_err pulse SHALL occur in the cycle after the stop-bit mid-sample edge, i.e. 2 synchronizer cycles + ~9.5 bit times after the start-bit falling edge on rx_pin.
REQ-020 A falling edge arriving on the same cycle IDLE is entered from STOP SHALL be detected on the next cycle (back-to-back frames with a 1-bit stop are received without loss).
REQ-021 rx_valid and rx_frame_err SHALL never be high in the same cycle.
REQ-022 There is no flow control; a new byte SHALL overwrite rx_data regardless of whether the previous one was consumed.

Reset
REQ-023 On rst low: state=IDLE, bitcnt=0, bit index=0, shift register=0, rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_busy=0, synchronizer flops=1 — all immediately, independent of clk.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rx_valid pulse; after release, reception SHALL restart only on a fresh falling edge.

Structure
REQ-025 A shared package uart_pkg SHALL hold the state encodings (IDLE..BREAK) and the default CLKDIV; uart_tx and uart_rx both use its CLKDIV.
REQ-026 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value parameter), reusable for other async inputs.
REQ-027 Outputs SHALL be registered; no combinational path from rx_pin to any output.

Verification
REQ-028 CLKDIV=16: drive frame 0x55 at 16 clk/bit -> exactly one rx_valid, rx_data=0x55, rx_frame_err never high.
REQ-029 CLKDIV=16: 5-cycle low glitch on idle line -> rx_busy rises then falls, no rx_valid, no rx_frame_err.
REQ-030 CLKDIV=16: frame 0xA3 with stop bit 0, line held low 40 cycles, then high -> one rx_frame_err pulse, rx_data keeps its previous value, state stays BREAK until line high, then IDLE.
REQ-031 CLKDIV=16: loopback from uart_tx sending 0x00, 0xFF, 0xA5 back-to-back -> three rx_valid pulses with those values in order, none lost.
REQ-032 CLKDIV=16: assert rst at bit 4 of frame 0x3C, release, then send 0xC3 -> no pulse for 0x3C, rx_data=0xC3 after the second frame.
REQ-033 Rate tolerance: frames of 0x96 sent at ±3% bit period -> rx_data=0x96 every frame.
